// File: rtl/reg_alu_seq_pkg.sv
// Purpose: shared constants, op codes and FSM encoding for the register/ALU sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_alu_pkg;

   localparam int WIDTH = 16;
   localparam int NREGS = 8;
   localparam int AW    = $clog2(NREGS);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      WB   = 2'b10
   } state_t;

   // Only the arithmetic ops produce a meaningful carry; logic ops leave the flag alone.
   function automatic logic op_sets_carry(input logic [1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/reg_alu_seq_if.sv
// Purpose: command channel into the sequencer (valid/ready plus command fields).
// Latency: n/a (wiring only).
// Backpressure: producer holds the command until cmd_ready is seen with cmd_valid.
interface reg_alu_seq_if;
   import reg_alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_ld;
   logic [1:0]        cmd_op;
   logic [AW-1:0]     cmd_rd;
   logic [AW-1:0]     cmd_rs1;
   logic [AW-1:0]     cmd_rs2;
   logic [WIDTH-1:0]  cmd_imm;

   modport master (
      output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      output cmd_ready
   );

endinterface

// File: rtl/reg_alu_seq_reg_file.sv
// Purpose: 8 x 16 register file, two async read ports, async debug read, one sync write.
// Latency: reads combinational; write visible the cycle after we_i.
// Backpressure: none; writes always accepted.
module reg_file_8x16
   import reg_alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra_addr_i,
   output logic [WIDTH-1:0] ra_data_o,
   input  logic [AW-1:0]    rb_addr_i,
   output logic [WIDTH-1:0] rb_data_o,
   input  logic [AW-1:0]    dbg_addr_i,
   output logic [WIDTH-1:0] dbg_data_o,
   input  logic             we_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i
);

   logic [WIDTH-1:0] regs_q [NREGS];

   // Storage: whole array clears on reset, single write port otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign ra_data_o  = regs_q[ra_addr_i];
   assign rb_data_o  = regs_q[rb_addr_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/reg_alu_seq.sv
// Purpose: register file + IDLE/EXEC/WB sequencer feeding an external combinational ALU.
// Latency: done 2 cycles after accept for ALU ops, 1 cycle for loads.
// Backpressure: cmd_ready high only in IDLE; optional zero flag under REG_ALU_ZFLAG_EN.
module reg_alu_seq
   import reg_alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   reg_alu_seq_if.slave     cmd,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_o,
   input  logic             alu_cout,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
`ifdef REG_ALU_ZFLAG_EN
   output logic             zero,
`endif
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   state_t           state_q, state_d;
   logic             ready_c;
   logic             done_c;
   logic             accept;
   logic [AW-1:0]    rd_q;
   logic [WIDTH-1:0] wb_val_q;
   logic [1:0]       alu_op_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic [WIDTH-1:0] rs1_data, rs2_data;

   reg_file_8x16 u_rf (
      .clk        (clk),
      .rst_n      (rst_n),
      .ra_addr_i  (cmd.cmd_rs1),
      .ra_data_o  (rs1_data),
      .rb_addr_i  (cmd.cmd_rs2),
      .rb_data_o  (rs2_data),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (state_q == WB),
      .wr_addr_i  (rd_q),
      .wr_data_i  (wb_val_q)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus handshake/done outputs; loads skip EXEC entirely.
   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (cmd.cmd_valid) begin
               state_d = cmd.cmd_ld ? WB : EXEC;
            end
         end
         EXEC: state_d = WB;
         WB: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept        = cmd.cmd_valid & ready_c;
   assign cmd.cmd_ready = ready_c;

   // Datapath: latch command on accept, capture ALU in EXEC, publish result in WB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q     <= '0;
         wb_val_q <= '0;
         alu_op_q <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else begin
         if (accept) begin
            rd_q <= cmd.cmd_rd;
            if (cmd.cmd_ld) begin
               wb_val_q <= cmd.cmd_imm;
            end else begin
               alu_a_q  <= rs1_data;
               alu_b_q  <= rs2_data;
               alu_op_q <= cmd.cmd_op;
            end
         end
         if (state_q == EXEC) begin
            wb_val_q <= alu_o;
            if (op_sets_carry(alu_op_q)) begin
               carry_q <= alu_cout;
            end
         end
         if (state_q == WB) begin
            result_q <= wb_val_q;
         end
      end
   end

`ifdef REG_ALU_ZFLAG_EN
   logic zero_q;

   // Zero flag tracks every write-back, loads included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else if (state_q == WB) begin
         zero_q <= (wb_val_q == '0);
      end
   end

   assign zero = zero_q;
`endif

   assign alu_op = alu_op_q;
   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign done   = done_c;
   assign result = result_q;
   assign carry  = carry_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Purpose: directed self-checking bench for reg_alu_seq with a behavioural ALU.
// Latency: checks done at accept+2 (ALU) and accept+1 (load).
// Backpressure: exercises held cmd_valid and reset during EXEC.
module tb_reg_alu_seq;
   import reg_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  alu_op;
   logic [15:0] alu_a, alu_b, alu_o;
   logic        alu_cout;
   logic        done;
   logic [15:0] result;
   logic        carry;
`ifdef REG_ALU_ZFLAG_EN
   logic        zero;
`endif
   logic [2:0]  dbg_addr = 3'd0;
   logic [15:0] dbg_data;

   int n_checks = 0;
   int n_fail   = 0;

   reg_alu_seq_if cmd_if ();

   reg_alu_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd      (cmd_if.slave),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_o    (alu_o),
      .alu_cout (alu_cout),
      .done     (done),
      .result   (result),
      .carry    (carry),
`ifdef REG_ALU_ZFLAG_EN
      .zero     (zero),
`endif
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   // External 16-bit ALU; logic ops report cout = 0 so a wrongly captured carry shows up.
   always_comb begin
      logic [16:0] s;
      s = 17'd0;
      case (alu_op)
         2'b00:   s = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01:   s = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
         2'b10:   s = {1'b0, alu_a & alu_b};
         default: s = {1'b0, alu_a | alu_b};
      endcase
      alu_o    = s[15:0];
      alu_cout = s[16];
   end

   task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
      dbg_addr = a;
      #1;
      d = dbg_data;
   endtask

   // Issue one command from IDLE; lat = 1 + edges after accept until done (or -1 on timeout).
   task automatic do_cmd(input logic ld, input logic [1:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [15:0] imm, output int lat);
      @(negedge clk);
      cmd_if.cmd_ld  = ld;
      cmd_if.cmd_op  = op;
      cmd_if.cmd_rd  = rd;
      cmd_if.cmd_rs1 = rs1;
      cmd_if.cmd_rs2 = rs2;
      cmd_if.cmd_imm = imm;
      cmd_if.cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      lat = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = i + 1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [15:0] d;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #2;
      for (int r = 0; r < 8; r++) begin
         read_reg(r[2:0], d);
         n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_reg r%0d got %h exp 0000", r, d); end
      end
      n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cmd_if.cmd_ready); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", carry); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h exp 0000", result); end
      n_checks++; if ({alu_op, alu_a, alu_b} !== 34'd0) begin n_fail++; $display("FAIL reset_alu_regs got %h %h %h exp 0", alu_op, alu_a, alu_b); end
`ifdef REG_ALU_ZFLAG_EN
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b exp 0", zero); end
`endif
   endtask

   task automatic test_add;
      int lat;
      logic [15:0] d;
      do_cmd(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'h0005, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL load_latency got %0d exp 1", lat); end
      n_checks++; if (result !== 16'h0005) begin n_fail++; $display("FAIL load_result got %h exp 0005", result); end
      do_cmd(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0003, lat);
      do_cmd(1'b0, OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d exp 2", lat); end
      n_checks++; if (alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_op !== OP_ADD) begin n_fail++; $display("FAIL add_operands got %h %h %h exp 0005 0003 0", alu_a, alu_b, alu_op); end
      n_checks++; if (result !== 16'h0008) begin n_fail++; $display("FAIL add_result got %h exp 0008", result); end
      read_reg(3'd3, d);
      n_checks++; if (d !== 16'h0008) begin n_fail++; $display("FAIL add_r3 got %h exp 0008", d); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL add_carry got %b exp 0", carry); end
   endtask

   task automatic test_sub;
      int lat;
      logic [15:0] d;
      do_cmd(1'b0, OP_SUB, 3'd4, 3'd2, 3'd1, 16'h0000, lat);
      read_reg(3'd4, d);
      n_checks++; if (d !== 16'hFFFE) begin n_fail++; $display("FAIL sub_borrow_r4 got %h exp fffe", d); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_carry got %b exp 0", carry); end
      do_cmd(1'b0, OP_SUB, 3'd5, 3'd1, 3'd2, 16'h0000, lat);
      read_reg(3'd5, d);
      n_checks++; if (d !== 16'h0002) begin n_fail++; $display("FAIL sub_r5 got %h exp 0002", d); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_carry got %b exp 1", carry); end
   endtask

   task automatic test_wrap;
      int lat;
      logic [15:0] d;
      do_cmd(1'b1, OP_ADD, 3'd6, 3'd0, 3'd0, 16'hFFFF, lat);
      do_cmd(1'b1, OP_ADD, 3'd7, 3'd0, 3'd0, 16'h0001, lat);
`ifdef REG_ALU_ZFLAG_EN
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL load_zero got %b exp 0", zero); end
`endif
      do_cmd(1'b0, OP_ADD, 3'd6, 3'd6, 3'd7, 16'h0000, lat);
      read_reg(3'd6, d);
      n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL wrap_r6 got %h exp 0000", d); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL wrap_result got %h exp 0000", result); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL wrap_carry got %b exp 1", carry); end
`ifdef REG_ALU_ZFLAG_EN
      n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got %b exp 1", zero); end
`endif
   endtask

   task automatic test_logic;
      int lat;
      logic [15:0] d;
      do_cmd(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'hF0F0, lat);
      do_cmd(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0FF0, lat);
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL load_keeps_carry got %b exp 1", carry); end
      do_cmd(1'b0, OP_AND, 3'd3, 3'd1, 3'd2, 16'h0000, lat);
      read_reg(3'd3, d);
      n_checks++; if (d !== 16'h00F0) begin n_fail++; $display("FAIL and_r3 got %h exp 00f0", d); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL and_carry got %b exp 1", carry); end
      do_cmd(1'b0, OP_OR, 3'd4, 3'd1, 3'd2, 16'h0000, lat);
      read_reg(3'd4, d);
      n_checks++; if (d !== 16'hFFF0) begin n_fail++; $display("FAIL or_r4 got %h exp fff0", d); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL or_carry got %b exp 1", carry); end
`ifdef REG_ALU_ZFLAG_EN
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL or_zero got %b exp 0", zero); end
`endif
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [15:0] d;
      // r5 = 0x00F0 + 0xFFF0 = 0x00E0 carry 1; then r6 = r5 - r3 = 0x00E0 - 0x00F0 = 0xFFF0 borrow.
      do_cmd(1'b0, OP_ADD, 3'd5, 3'd3, 3'd4, 16'h0000, lat);
      do_cmd(1'b0, OP_SUB, 3'd6, 3'd5, 3'd3, 16'h0000, lat);
      read_reg(3'd6, d);
      n_checks++; if (d !== 16'hFFF0) begin n_fail++; $display("FAIL dep_r6 got %h exp fff0", d); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL dep_carry got %b exp 0", carry); end
      // Same register as both sources and destination: 0x8001 + 0x8001 = 0x0002 carry 1.
      do_cmd(1'b1, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h8001, lat);
      do_cmd(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 16'h0000, lat);
      read_reg(3'd0, d);
      n_checks++; if (d !== 16'h0002) begin n_fail++; $display("FAIL self_r0 got %h exp 0002", d); end
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL self_carry got %b exp 1", carry); end
   endtask

   task automatic test_hold_valid;
      int accepts = 0;
      int dones = 0;
      logic [15:0] d;
      @(negedge clk);
      cmd_if.cmd_ld  = 1'b0;
      cmd_if.cmd_op  = OP_ADD;
      cmd_if.cmd_rd  = 3'd7;
      cmd_if.cmd_rs1 = 3'd1;
      cmd_if.cmd_rs2 = 3'd2;
      cmd_if.cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (cmd_if.cmd_ready === 1'b1) accepts++;
         if (done === 1'b1) dones++;
      end
      cmd_if.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (accepts !== 2) begin n_fail++; $display("FAIL hold_accepts got %0d exp 2", accepts); end
      n_checks++; if (dones !== 2) begin n_fail++; $display("FAIL hold_dones got %0d exp 2", dones); end
      read_reg(3'd7, d);
      n_checks++; if (d !== 16'h00E0) begin n_fail++; $display("FAIL hold_r7 got %h exp 00e0", d); end
   endtask

   task automatic test_reset_mid;
      int lat;
      int dones = 0;
      logic [15:0] d;
      do_cmd(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'h1234, lat);
      read_reg(3'd1, d);
      n_checks++; if (d !== 16'h1234) begin n_fail++; $display("FAIL pre_reset_r1 got %h exp 1234", d); end
      @(negedge clk);
      cmd_if.cmd_ld  = 1'b0;
      cmd_if.cmd_op  = OP_ADD;
      cmd_if.cmd_rd  = 3'd2;
      cmd_if.cmd_rs1 = 3'd1;
      cmd_if.cmd_rs2 = 3'd1;
      cmd_if.cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", cmd_if.cmd_ready); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", done); end
      for (int r = 0; r < 8; r++) begin
         read_reg(r[2:0], d);
         n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_reg r%0d got %h exp 0000", r, d); end
      end
      n_checks++; if (carry !== 1'b0 || result !== 16'h0000) begin n_fail++; $display("FAIL midrst_flags got %b %h exp 0 0000", carry, result); end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d exp 0", dones); end
      read_reg(3'd2, d);
      n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL midrst_r2 got %h exp 0000", d); end
   endtask

   initial begin
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_ld    = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_rd    = 3'd0;
      cmd_if.cmd_rs1   = 3'd0;
      cmd_if.cmd_rs2   = 3'd0;
      cmd_if.cmd_imm   = 16'h0000;
      test_reset();
      test_add();
      test_sub();
      test_wrap();
      test_logic();
      test_back_to_back();
      test_hold_valid();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
Register-file and operation sequencer that sits directly upstream of the 16-bit ALU and also consumes its result.
- Holds 8 x 16-bit general registers.
- Accepts one command at a time over a valid/ready handshake.
- Reads two source registers and drives them plus the op code to the combinational ALU.
- Captures the ALU result and carry, then writes the result back to the destination register.
- Also supports immediate loads so software/bench can initialise registers.

Parameters:
NREGS, 8, number of general registers (address width = log2(NREGS) = 3)
WIDTH, 16, data width; fixed to match the ALU datapath

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_ld  in  1  1 = load immediate into rd; 0 = ALU operation
cmd_op  in  2  ALU op: 00 add, 01 sub (rs1 - rs2), 10 and, 11 or
cmd_rd  in  3  destination register
cmd_rs1  in  3  source register A
cmd_rs2  in  3  source register B
cmd_imm  in  16  immediate value for load
alu_op  out  2  op code to ALU, registered
alu_a  out  16  ALU operand i0, registered
alu_b  out  16  ALU operand i1, registered
alu_o  in  16  ALU result
alu_cout  in  1  ALU carry out (for sub: 1 = no borrow)
done  out  1  one-cycle pulse when write-back commits
result  out  16  value written at the last write-back
carry  out  1  carry flag
dbg_addr  in  3  debug read address
dbg_data  out  16  combinational read of register dbg_addr

Behaviour:
- Reset (rst_n low, async):
  - All registers 0; state IDLE.
  - alu_op, alu_a, alu_b, result, carry, done all 0.
  - cmd_ready = 1 once in IDLE.
- State machine IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready with cmd_ld = 1: latch rd and imm, go to WB.
  - On cmd_valid & cmd_ready with cmd_ld = 0: latch rd and op; load alu_a <= reg[rs1], alu_b <= reg[rs2], alu_op <= cmd_op; go to EXEC.
- EXEC:
  - cmd_ready = 0.
  - The ALU is combinational. At the end of EXEC, capture alu_o into the internal result register.
  - carry <= alu_cout only for ops 00/01; for and/or, carry is unchanged.
  - Go to WB.
- WB:
  - reg[rd] <= captured value; result <= same value; done = 1 for exactly this cycle.
  - Go to IDLE.
- Latency: accept at cycle N; done at N+2 for ALU ops, N+1 for loads. Throughput is one ALU command per 3 cycles or one load per 2 cycles.
- No hazards: write-back commits before the next accept, so back-to-back dependent commands read updated values. rd == rs1 == rs2 is legal.
- cmd_valid while cmd_ready = 0 is ignored; the command is neither lost nor required to be held by this block (the producer holds it per the handshake).
- alu_a, alu_b and alu_op hold their values outside EXEC.
- Reset mid-EXEC or mid-WB returns to IDLE immediately; the pending write is discarded and all registers clear.
- Arithmetic is modulo 2^16; the carry flag alone reports overflow/borrow.

Optional Feature:
REG_ALU_ZFLAG_EN
- Defined: adds output port zero (1 bit, reset 0), set in WB to (written value == 0) for both ALU ops and loads.
- Undefined: no zero port and no extra logic.

Decomposition:
- Package reg_alu_pkg holds:
  - op constants OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11;
  - state encoding IDLE/EXEC/WB;
  - WIDTH and register-address width constants.
- One natural sub-module, reg_file_8x16: two asynchronous read ports plus a debug read port, one synchronous write port, async active-low clear.

Test Plan:
- Reset: after rst_n deasserts, dbg read of r0..r7 = 0x0000, cmd_ready = 1, done = 0, carry = 0.
- Load r1 = 0x0005 and r2 = 0x0003, then ADD rd = r3 -> done two cycles after accept, result = 0x0008, r3 = 0x0008, carry = 0.
- SUB r4 = r2 - r1 -> 0xFFFE, carry = 0; SUB r5 = r1 - r2 -> 0x0002, carry = 1.
- Load r6 = 0xFFFF, r7 = 0x0001, ADD r6 = r6 + r7 -> r6 = 0x0000, carry = 1, zero = 1 when REG_ALU_ZFLAG_EN.
- Load r1 = 0xF0F0, r2 = 0x0FF0:
  - AND r3 -> 0x00F0;
  - OR r4 -> 0xFFF0;
  - carry keeps its prior value in both cases.
- Handshake and reset:
  - Hold cmd_valid high through EXEC/WB -> exactly one command accepted per IDLE.
  - Assert rst_n low during EXEC -> no write to rd, state returns to IDLE, all registers read 0.
